event_builder_mux: RTL

- Parametrised successor to the fixed 16-channel / 48-column data multiplexer.
- On each readout request, walks the per-channel column memories and packs the channel data with header, event number, column index and footer into a 32-bit word stream for the readout FIFO.
- Adds configurable channel count, column depth and memory read latency, FIFO back-pressure, and trigger-overrun counting.
- Sits between the per-channel memory buffers and the readout FIFO.

---
 rtl/evb_pkg.sv | 26 ++
 rtl/evb_edge_det.sv | 26 ++
 rtl/event_builder_mux.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/evb_pkg.sv
// Shared types and constants for the event builder multiplexer.
package evb_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_HDR,
        ST_COL_WAIT,
        ST_MEM_WAIT,
        ST_CAPTURE,
        ST_COL_HDR,
        ST_DATA,
        ST_COL_TRL,
        ST_FTR
    } evb_state_e;

    localparam logic [31:0] EV_HDR_DEF = 32'hAAAAAAAA;
    localparam logic [31:0] EV_FTR_DEF = 32'hF0F0F0F0;

    // Words written for one complete event: header, footer and per column
    // one column header, N_CH/2 data words and one column trailer.
    function automatic int unsigned words_per_event(input int unsigned n_ch,
                                                    input int unsigned depth);
        return 2 + depth * (n_ch / 2 + 2);
    endfunction

endpackage

// File: rtl/evb_edge_det.sv
// Synchronous rising-edge detector for the readout request level.
// The previous-sample register resets to 1 so a level already high when
// reset is released is not mistaken for a new request.
module evb_edge_det (
    input  logic CLK,
    input  logic RST_N,
    input  logic sig,
    output logic rise
);

    logic prev_q;

    // Register the previous sample and a one-cycle pulse on a 0->1 change.
    always_ff @(posedge CLK or negedge RST_N) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (!RST_N) begin
            prev_q <= 1'b1;
            rise   <= 1'b0;
        end else begin
            prev_q <= sig;
            rise   <= sig & ~prev_q;
        end
    end

endmodule

// File: rtl/event_builder_mux.sv
// Event builder: on each readout request walks the channel column memories
// and packs header, column headers, paired channel data, column trailers
// and footer into a 32-bit word stream for the readout FIFO.
module event_builder_mux
    import evb_pkg::*;
#(
    parameter int          N_CH    = 16,
    parameter int          DEPTH   = 48,
    parameter int          ADDR_W  = 6,
    parameter int          MEM_LAT = 2,
    parameter logic [31:0] EV_HDR  = EV_HDR_DEF,
    parameter logic [31:0] EV_FTR  = EV_FTR_DEF
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                MEM_RD_FLAG,
    input  logic [15:0]         DATA_H,
    input  logic [15:0]         DATA_F,
    input  logic [16*N_CH-1:0]  DATA_IN,
    output logic [ADDR_W-1:0]   MEM_ADDR_OUT,
    input  logic                FIFO_PROG_FULL,
    output logic [31:0]         DATA_OUT,
    output logic                FIFO_WR_EN,
    output logic                BUSY,
    output logic [15:0]         EVENT_NUMBER,
    output logic [15:0]         OVERRUN_CNT
);

    localparam int                N_PAIR    = N_CH / 2;
    localparam int                IDX_W     = (N_PAIR > 1) ? $clog2(N_PAIR) : 1;
    localparam logic [ADDR_W-1:0] LAST_COL  = ADDR_W'(DEPTH - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(N_PAIR - 1);
    localparam logic [2:0]        LAST_WAIT = 3'(MEM_LAT - 1);

    evb_state_e                   state_q, state_d;
    logic [ADDR_W-1:0]            col_q;
    logic [IDX_W-1:0]             idx_q;
    logic [2:0]                   wait_q;
    logic [N_PAIR-1:0][31:0]      cap_pairs_q;   // pair i = {ch[2i+1], ch[2i]}
    logic [15:0]                  cap_h_q;
    logic [15:0]                  cap_f_q;
    logic                         trig_rise;
    logic                         wr_d;
    logic [31:0]                  dout_d;

    evb_edge_det u_edge (
        .CLK   (CLK),
        .RST_N (RST_N),
        .sig   (MEM_RD_FLAG),
        .rise  (trig_rise)
    );

    // State register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next state and the next output word / write strobe.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d = state_q;
        wr_d    = 1'b0;
        dout_d  = DATA_OUT;
        unique case (state_q)
            ST_IDLE: begin
                if (trig_rise) state_d = ST_HDR;
            end
            ST_HDR: begin
                wr_d    = 1'b1;
                dout_d  = EV_HDR;
                state_d = ST_COL_WAIT;
            end
            ST_COL_WAIT: begin
                // Only point where back-pressure is honoured; a started
                // column is always written out without gaps.
                if (!FIFO_PROG_FULL) state_d = ST_MEM_WAIT;
            end
            ST_MEM_WAIT: begin
                if (wait_q == LAST_WAIT) state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                state_d = ST_COL_HDR;
            end
            ST_COL_HDR: begin
                wr_d    = 1'b1;
                dout_d  = {cap_h_q, EVENT_NUMBER};
                state_d = ST_DATA;
            end
            ST_DATA: begin
                wr_d   = 1'b1;
                dout_d = cap_pairs_q[idx_q];
                if (idx_q == LAST_IDX) state_d = ST_COL_TRL;
            end
            ST_COL_TRL: begin
                wr_d    = 1'b1;
                dout_d  = {cap_f_q, 16'(col_q)};
                state_d = (col_q == LAST_COL) ? ST_FTR : ST_COL_WAIT;
            end
            ST_FTR: begin
                wr_d    = 1'b1;
                dout_d  = EV_FTR;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Counters, capture bank, registered outputs and event bookkeeping.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            // NOTE: the capture bank is a handful of flops, not a RAM, so it
            // is cleared with everything else to keep reset state defined.
            col_q        <= '0;
            idx_q        <= '0;
            wait_q       <= '0;
            cap_pairs_q  <= '0;
            cap_h_q      <= '0;
            cap_f_q      <= '0;
            MEM_ADDR_OUT <= '0;
            DATA_OUT     <= '0;
            FIFO_WR_EN   <= 1'b0;
            BUSY         <= 1'b0;
            EVENT_NUMBER <= '0;
            OVERRUN_CNT  <= '0;
        end else begin
            FIFO_WR_EN <= wr_d;
            DATA_OUT   <= dout_d;
            // Busy stays up through the cycle that presents the footer.
            BUSY       <= (state_d != ST_IDLE) || wr_d;

            if (trig_rise && state_q == ST_IDLE) begin
                EVENT_NUMBER <= EVENT_NUMBER + 16'd1;
                col_q        <= '0;
            end else if (trig_rise && OVERRUN_CNT != 16'hFFFF) begin
                OVERRUN_CNT <= OVERRUN_CNT + 16'd1;
            end

            if (state_q == ST_COL_WAIT && !FIFO_PROG_FULL) begin
                MEM_ADDR_OUT <= col_q;
                wait_q       <= '0;
            end

            if (state_q == ST_MEM_WAIT) wait_q <= wait_q + 3'd1;

            if (state_q == ST_CAPTURE) begin
                cap_pairs_q <= DATA_IN;
                cap_h_q     <= DATA_H;
                cap_f_q     <= DATA_F;
                idx_q       <= '0;
            end

            if (state_q == ST_DATA) idx_q <= idx_q + IDX_W'(1);

            if (state_q == ST_COL_TRL && col_q != LAST_COL) col_q <= col_q + ADDR_W'(1);
        end
    end

endmodule
